// File: rtl/ov5640_cap_pkg.sv
// Shared types and widths for the OV5640 RGB565 capture stage.
//   RGB565_W : packed pixel width
//   CNT_W    : width of the per-line / per-frame statistics counters
//   SKIP_W   : width of the start-up frame skip counter
//   cap_state_e : capture FSM states
package ov5640_cap_pkg;

  localparam int unsigned RGB565_W = 16;
  localparam int unsigned CNT_W    = 12;
  localparam int unsigned SKIP_W   = 8;

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    SKIP     = 2'd1,
    ACTIVE   = 2'd2
  } cap_state_e;

endpackage

// File: rtl/ov5640_byte_pack.sv
// Packs consecutive sensor bytes of a line into RGB565 pixels.
// Ports:
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   href_r0    : registered line-valid
//   data_r0    : registered sensor byte
//   data       : last completed pixel {first byte, second byte}, held between strobes
//   clken      : one-cycle strobe when data carries a new pixel
module ov5640_byte_pack
  import ov5640_cap_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                href_r0,
  input  logic [7:0]          data_r0,
  output logic [RGB565_W-1:0] data,
  output logic                clken
);

  logic                toggle_q, toggle_d;
  logic [7:0]          hi_q, hi_d;
  logic [RGB565_W-1:0] data_q, data_d;
  logic                clken_q, clken_d;

  always_comb begin
    toggle_d = toggle_q;
    hi_d     = hi_q;
    data_d   = data_q;
    clken_d  = 1'b0;
    if (href_r0) begin
      if (!toggle_q) begin
        hi_d     = data_r0;
        toggle_d = 1'b1;
      end else begin
        data_d   = {hi_q, data_r0};
        clken_d  = 1'b1;
        toggle_d = 1'b0;
      end
    end else begin
      // Every line restarts on a first byte; an odd trailing byte is dropped.
      toggle_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q <= 1'b0;
      hi_q     <= '0;
      data_q   <= '0;
      clken_q  <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
      hi_q     <= hi_d;
      data_q   <= data_d;
      clken_q  <= clken_d;
    end
  end

  assign data  = data_q;
  assign clken = clken_q;

endmodule

// File: rtl/ov5640_rgb565_capture.sv
// OV5640 DVP capture: after config_done, drops FRAME_SKIP frames, then emits whole frames of
// RGB565 pixels with vsync/href/clken aligned to the pixel data (2-cycle latency).
// Ports:
//   clk, rst_n        : sensor pixel clock, asynchronous active-low reset
//   config_done       : SCCB init finished (level)
//   cmos_vsync/href   : sensor frame / line valid
//   cmos_data         : sensor byte bus
//   cmos_frame_*      : gated, aligned vsync/href, pixel strobe and RGB565 pixel
// Optional build macro OV5640_CAPTURE_STATS_EN adds line_pix_cnt, frame_line_cnt,
// frame_cnt and a sticky frame_err geometry check against H_PIXELS x V_LINES.
module ov5640_rgb565_capture
  import ov5640_cap_pkg::*;
#(
  parameter int unsigned FRAME_SKIP = 10,
  parameter int unsigned H_PIXELS   = 800,
  parameter int unsigned V_LINES    = 480
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                config_done,
  input  logic                cmos_vsync,
  input  logic                cmos_href,
  input  logic [7:0]          cmos_data,
  output logic                cmos_frame_vsync,
  output logic                cmos_frame_href,
  output logic                cmos_frame_clken,
  output logic [RGB565_W-1:0] cmos_frame_data
`ifdef OV5640_CAPTURE_STATS_EN
  ,
  output logic [CNT_W-1:0]    line_pix_cnt,
  output logic [CNT_W-1:0]    frame_line_cnt,
  output logic [7:0]          frame_cnt,
  output logic                frame_err
`endif
);

  localparam logic [SKIP_W-1:0] SkipTarget = SKIP_W'(FRAME_SKIP);

  if (FRAME_SKIP < 1 || FRAME_SKIP > 255 || H_PIXELS >= (1 << CNT_W) ||
      V_LINES >= (1 << CNT_W)) begin : gen_param_check
    $error("ov5640_rgb565_capture: parameter out of range");
  end

  // Input stage: r0 is the registered sensor bus, r1 one more cycle of delay.
  logic       vs_r0_q, vs_r1_q;
  logic       href_r0_q, href_r1_q;
  logic [7:0] data_r0_q;
  logic       vs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r0_q   <= 1'b0;
      vs_r1_q   <= 1'b0;
      href_r0_q <= 1'b0;
      href_r1_q <= 1'b0;
      data_r0_q <= '0;
    end else begin
      vs_r0_q   <= cmos_vsync;
      vs_r1_q   <= vs_r0_q;
      href_r0_q <= cmos_href;
      href_r1_q <= href_r0_q;
      data_r0_q <= cmos_data;
    end
  end

  assign vs_rise = vs_r0_q & ~vs_r1_q;

  // Capture FSM
  cap_state_e        state_q, state_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic              active;

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    if (!config_done) begin
      state_d    = WAIT_CFG;
      skip_cnt_d = '0;
    end else begin
      case (state_q)
        WAIT_CFG: begin
          state_d    = SKIP;
          skip_cnt_d = '0;
        end
        SKIP: begin
          // FRAME_SKIP frame starts are discarded; the next one opens the first output frame.
          if (vs_rise) begin
            if (skip_cnt_q == SkipTarget) begin
              state_d    = ACTIVE;
              skip_cnt_d = '0;
            end else begin
              skip_cnt_d = skip_cnt_q + 1'b1;
            end
          end
        end
        ACTIVE: state_d = ACTIVE;
        default: begin
          state_d    = WAIT_CFG;
          skip_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_CFG;
      skip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign active = (state_q == ACTIVE);

  // Pixel path
  logic [RGB565_W-1:0] pix_data;
  logic                pix_valid;

  ov5640_byte_pack u_byte_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .href_r0 (href_r0_q),
    .data_r0 (data_r0_q),
    .data    (pix_data),
    .clken   (pix_valid)
  );

  assign cmos_frame_vsync = vs_r1_q & active;
  assign cmos_frame_href  = href_r1_q & active;
  assign cmos_frame_clken = pix_valid & active;
  assign cmos_frame_data  = active ? pix_data : '0;

`ifdef OV5640_CAPTURE_STATS_EN
  localparam logic [CNT_W-1:0] HPixCmp  = CNT_W'(H_PIXELS);
  localparam logic [CNT_W-1:0] VLineCmp = CNT_W'(V_LINES);

  logic [CNT_W-1:0] line_pix_cnt_q, line_pix_cnt_d;
  logic [CNT_W-1:0] frame_line_cnt_q, frame_line_cnt_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             frame_err_q, frame_err_d;
  logic             line_bad_q, line_bad_d;
  logic             href_fall;
  logic             entering;
  logic [CNT_W-1:0] line_len;

  assign href_fall = href_r1_q & ~href_r0_q;
  assign entering  = (state_q != ACTIVE) && (state_d == ACTIVE);
  // The last pixel of a line strobes in the same cycle the registered href falls.
  assign line_len  = line_pix_cnt_q + CNT_W'(pix_valid);

  always_comb begin
    line_pix_cnt_d   = line_pix_cnt_q;
    frame_line_cnt_d = frame_line_cnt_q;
    frame_cnt_d      = frame_cnt_q;
    frame_err_d      = frame_err_q;
    line_bad_d       = line_bad_q;
    if (active) begin
      if (pix_valid) line_pix_cnt_d = line_pix_cnt_q + 1'b1;
      if (href_fall) begin
        line_pix_cnt_d   = '0;
        frame_line_cnt_d = frame_line_cnt_q + 1'b1;
        if (line_len != HPixCmp) line_bad_d = 1'b1;
      end
      if (vs_rise) begin
        frame_cnt_d = frame_cnt_q + 1'b1;
        if (line_bad_q || (frame_line_cnt_q != VLineCmp)) frame_err_d = 1'b1;
        frame_line_cnt_d = '0;
        line_bad_d       = 1'b0;
      end
    end else if (entering) begin
      // Discard leftovers of an earlier aborted ACTIVE period.
      line_pix_cnt_d   = '0;
      frame_line_cnt_d = '0;
      line_bad_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_pix_cnt_q   <= '0;
      frame_line_cnt_q <= '0;
      frame_cnt_q      <= '0;
      frame_err_q      <= 1'b0;
      line_bad_q       <= 1'b0;
    end else begin
      line_pix_cnt_q   <= line_pix_cnt_d;
      frame_line_cnt_q <= frame_line_cnt_d;
      frame_cnt_q      <= frame_cnt_d;
      frame_err_q      <= frame_err_d;
      line_bad_q       <= line_bad_d;
    end
  end

  assign line_pix_cnt   = line_pix_cnt_q;
  assign frame_line_cnt = frame_line_cnt_q;
  assign frame_cnt      = frame_cnt_q;
  assign frame_err      = frame_err_q;
`endif

endmodule

// File: tb/tb_ov5640_rgb565_capture.sv
// Self-checking bench for ov5640_rgb565_capture with FRAME_SKIP=2, H_PIXELS=4, V_LINES=2.
// Frames are generated with random pixel bytes; the expected pixel stream of each frame is
// derived from frame-level rules (which frames are shown, byte pairs per line).
module tb_ov5640_rgb565_capture;

  localparam int unsigned FrameSkip = 2;
  localparam int unsigned HPix      = 4;
  localparam int unsigned VLines    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        config_done = 1'b0;
  logic        cmos_vsync = 1'b0;
  logic        cmos_href = 1'b0;
  logic [7:0]  cmos_data = 8'h00;
  logic        cmos_frame_vsync;
  logic        cmos_frame_href;
  logic        cmos_frame_clken;
  logic [15:0] cmos_frame_data;
`ifdef OV5640_CAPTURE_STATS_EN
  logic [11:0] line_pix_cnt;
  logic [11:0] frame_line_cnt;
  logic [7:0]  frame_cnt;
  logic        frame_err;
`endif

  ov5640_rgb565_capture #(
    .FRAME_SKIP (FrameSkip),
    .H_PIXELS   (HPix),
    .V_LINES    (VLines)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .config_done      (config_done),
    .cmos_vsync       (cmos_vsync),
    .cmos_href        (cmos_href),
    .cmos_data        (cmos_data),
    .cmos_frame_vsync (cmos_frame_vsync),
    .cmos_frame_href  (cmos_frame_href),
    .cmos_frame_clken (cmos_frame_clken),
    .cmos_frame_data  (cmos_frame_data)
`ifdef OV5640_CAPTURE_STATS_EN
    ,
    .line_pix_cnt     (line_pix_cnt),
    .frame_line_cnt   (frame_line_cnt),
    .frame_cnt        (frame_cnt),
    .frame_err        (frame_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sensor inputs as they were two cycles ago, for checking output alignment.
  logic vs_d1 = 1'b0, vs_d2 = 1'b0, href_d1 = 1'b0, href_d2 = 1'b0;
  always @(posedge clk) begin
    vs_d1   <= cmos_vsync;
    vs_d2   <= vs_d1;
    href_d1 <= cmos_href;
    href_d2 <= href_d1;
  end

  // Output monitor (only this process writes these).
  logic [15:0] obs_q[$];
  int          obs_cyc[$];
  int          vs_cnt = 0, href_cnt = 0, nz_cnt = 0, align_bad = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmos_frame_clken) begin
        obs_q.push_back(cmos_frame_data);
        obs_cyc.push_back(cyc);
      end
      if (cmos_frame_vsync) vs_cnt++;
      if (cmos_frame_href) href_cnt++;
      if (cmos_frame_vsync || cmos_frame_href || cmos_frame_clken || cmos_frame_data != 16'h0)
        nz_cnt++;
      if ((cmos_frame_href && !href_d2) || (cmos_frame_vsync && !vs_d2)) align_bad++;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference state: frame starts seen with config_done high, previous-frame bookkeeping.
  int rises = 0;
  bit last_out = 1'b0;
  bit last_bad = 1'b0;
  int exp_frame_cnt = 0;
  bit exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    cmos_vsync = v;
    cmos_href  = h;
    cmos_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic set_cfg(input bit v);
    config_done = v;
    if (!v) begin
      rises    = 0;
      last_out = 1'b0;
    end
    idle(3);
  endtask

  // evt_byte >= 0: on line 0 at that byte index config_done is set to evt_val.
  task automatic send_frame(input int lines, input int bpl, input bit fixed_start,
                            input int evt_byte, input bit evt_val);
    logic [15:0] exp_q[$];
    logic [7:0]  hi, d;
    int          rd0, vs0, hr0, nz0, al0, mark;
    bit          out, bad, has_drop, incl;
    rd0 = obs_q.size();
    vs0 = vs_cnt;
    hr0 = href_cnt;
    nz0 = nz_cnt;
    al0 = align_bad;
    mark = 0;
    hi = 8'h00;
    has_drop = (evt_byte >= 0) && !evt_val;
`ifdef OV5640_CAPTURE_STATS_EN
    if (last_out && config_done) begin
      exp_frame_cnt++;
      if (last_bad) exp_err = 1'b1;
    end
`endif
    if (config_done) rises++;
    out = config_done && (rises > FrameSkip);
    bad = (lines != VLines);
    drive(1'b1, 1'b0, 8'($urandom));
    drive(1'b1, 1'b0, 8'($urandom));
    idle(3);
`ifdef OV5640_CAPTURE_STATS_EN
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_frame_cnt & 8'hFF));
    chk("frame_err", 32'(frame_err), 32'(exp_err));
`endif
    for (int l = 0; l < lines; l++) begin
      for (int b = 0; b < bpl; b++) begin
        d = 8'($urandom);
        if (fixed_start && l == 0 && b == 0) d = 8'hA5;
        if (fixed_start && l == 0 && b == 1) begin
          d = 8'h5A;
          mark = cyc;
        end
        if (l == 0 && b == evt_byte) begin
          config_done = evt_val;
          if (!evt_val) rises = 0;
        end
        // After a drop, only pairs finished two cycles before it still reach the output.
        incl = out && !(has_drop && (l > 0 || b >= evt_byte - 1));
        if (b % 2 == 0) hi = d;
        else if (incl) exp_q.push_back({hi, d});
        drive(1'b0, 1'b1, d);
        if (has_drop && l == 0 && b == evt_byte) begin
          chk("drop_vsync", 32'(cmos_frame_vsync), 32'd0);
          chk("drop_href", 32'(cmos_frame_href), 32'd0);
          chk("drop_clken", 32'(cmos_frame_clken), 32'd0);
          chk("drop_data", 32'(cmos_frame_data), 32'd0);
        end
      end
      if ((bpl / 2) != HPix) bad = 1'b1;
      idle(3);
    end
    idle(4);
    chk("pix_count", 32'(obs_q.size() - rd0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rd0 + i < obs_q.size()) chk("pix_data", 32'(obs_q[rd0 + i]), 32'(exp_q[i]));
    end
    if (fixed_start && out && obs_q.size() > rd0)
      chk("latency", 32'(obs_cyc[rd0] - mark), 32'd2);
    if (out && !has_drop) begin
      chk("vsync_cycles", 32'(vs_cnt - vs0), 32'd2);
      chk("href_cycles", 32'(href_cnt - hr0), 32'(lines * bpl));
    end
    if (!out) chk("quiet", 32'(nz_cnt - nz0), 32'd0);
    chk("align", 32'(align_bad - al0), 32'd0);
    last_out = out && !has_drop;
    last_bad = bad;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vsync", 32'(cmos_frame_vsync), 32'd0);
    chk("rst_href", 32'(cmos_frame_href), 32'd0);
    chk("rst_clken", 32'(cmos_frame_clken), 32'd0);
    chk("rst_data", 32'(cmos_frame_data), 32'd0);
`ifdef OV5640_CAPTURE_STATS_EN
    chk("rst_line_pix", 32'(line_pix_cnt), 32'd0);
    chk("rst_frame_line", 32'(frame_line_cnt), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
`endif
    rst_n = 1'b1;
    idle(2);

    // No configuration: nothing may come out.
    repeat (3) send_frame(2, 8, 1'b0, -1, 1'b0);

    // Configure between frames: two frames skipped, third shown with A5,5A first.
    set_cfg(1'b1);
    send_frame(2, 8, 1'b0, -1, 1'b0);
    send_frame(2, 8, 1'b0, -1, 1'b0);
    send_frame(2, 8, 1'b1, -1, 1'b0);

    // Odd-length lines, then a regular frame.
    send_frame(2, 7, 1'b0, -1, 1'b0);
    send_frame(2, 8, 1'b0, -1, 1'b0);

    // Drop config mid-line, then re-raise: skip count restarts.
    send_frame(2, 8, 1'b0, 3, 1'b0);
    set_cfg(1'b1);
    send_frame(2, 8, 1'b0, -1, 1'b0);
    send_frame(2, 8, 1'b0, -1, 1'b0);
    send_frame(2, 8, 1'b0, -1, 1'b0);
    send_frame(2, 8, 1'b0, -1, 1'b0);

    // Config raised in the middle of a frame.
    set_cfg(1'b0);
    send_frame(2, 8, 1'b0, 2, 1'b1);
    send_frame(2, 8, 1'b0, -1, 1'b0);
    send_frame(2, 8, 1'b0, -1, 1'b0);
    send_frame(2, 8, 1'b0, -1, 1'b0);

    // Random geometry.
    for (int f = 0; f < 5; f++)
      send_frame(int'($urandom_range(3, 1)), int'($urandom_range(10, 1)), 1'b0, -1, 1'b0);
    send_frame(2, 8, 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
